// File: rtl/bus_read_sequencer.sv
// -----------------------------------------------------------------------------
// bus_read_sequencer
//
// Reader side of the register file. Takes a burst command (start register,
// beat count) and drives one stored register word per bus beat onto the
// shared data bus using a valid/ready handshake. The register index wraps
// modulo NUM_REGS, so bursts longer than NUM_REGS reread registers in order.
//
// Ports
//   clk          clock, all logic on posedge
//   reset        synchronous, active-high
//   reg_data_i   register bank outputs, reg i at [i*WIDTH +: WIDTH]
//   cmd_valid_i  burst command present
//   cmd_ready_o  sequencer can accept a command (IDLE only)
//   cmd_sel_i    first register index
//   cmd_count_i  number of beats
//   bus_data_o   word driven on the bus
//   bus_sel_o    index of the register in bus_data_o
//   bus_valid_o  bus_data_o / bus_sel_o valid
//   bus_ready_i  consumer accepts the current beat
//   busy_o       burst in progress (DRIVE or DONE)
//   done_o       one-cycle pulse, burst completed
//   err_o        one-cycle pulse, command rejected
//
// State   | Meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for a command, cmd_ready_o high (except after reset)
// S_DRIVE | beat on the bus, advancing on every handshake
// S_DONE  | single cycle after the last handshake, done_o high
// -----------------------------------------------------------------------------
module bus_read_sequencer #(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH*NUM_REGS-1:0] reg_data_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [SEL_W-1:0]          cmd_sel_i,
    input  logic [CNT_W-1:0]          cmd_count_i,
    output logic [WIDTH-1:0]          bus_data_o,
    output logic [SEL_W-1:0]          bus_sel_o,
    output logic                      bus_valid_o,
    input  logic                      bus_ready_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One extra bit so the range check also works when NUM_REGS == 2**SEL_W.
    localparam logic [SEL_W:0]   NUM_REGS_X = (SEL_W+1)'(NUM_REGS);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_REGS - 1);

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               valid_q, valid_d;
    logic               err_q,   err_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;

    logic [SEL_W-1:0]   nxt_sel;
    logic [SEL_W-1:0]   rd_idx;
    logic [WIDTH-1:0]   rd_word;
    logic               sel_in_range;

    // Wrap modulo NUM_REGS rather than 2**SEL_W.
    assign nxt_sel      = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
    assign sel_in_range = ({1'b0, cmd_sel_i} < NUM_REGS_X);

    // In IDLE the word for the first beat is fetched, otherwise the next beat.
    assign rd_idx  = (state_q == S_IDLE) ? cmd_sel_i : nxt_sel;
    assign rd_word = reg_data_i[rd_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        data_d  = data_q;
        sel_d   = sel_q;
        rem_d   = rem_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && ready_q) begin
                    if ((cmd_count_i == '0) || !sel_in_range) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_DRIVE;
                        valid_d = 1'b1;
                        sel_d   = cmd_sel_i;
                        data_d  = rd_word;
                        rem_d   = cmd_count_i;
                    end
                end
            end
            S_DRIVE: begin
                // valid_q is always set here; a stall simply holds everything.
                if (bus_ready_i) begin
                    if (rem_q > CNT_W'(1)) begin
                        sel_d  = nxt_sel;
                        data_d = rd_word;
                        rem_d  = rem_q - CNT_W'(1);
                    end else begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Registered so that ready stays low during the reset cycle.
    assign ready_d = (state_d == S_IDLE);

    assign cmd_ready_o = ready_q;
    assign bus_valid_o = valid_q;
    assign bus_data_o  = data_q;
    assign bus_sel_o   = sel_q;
    assign err_o       = err_q;
    assign done_o      = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_read_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_read_sequencer
//
// Directed bench for bus_read_sequencer. Instance A uses the default
// parameters (8 registers, reg i = 16'h1000+i). Instance B uses 6 registers
// with a 4-bit index (reg i = 16'h2000+i) so out-of-range selects and
// non-power-of-2 wrap can be driven.
// -----------------------------------------------------------------------------
module tb_bus_read_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [127:0] rd_a;
    logic         cv_a, cr_a, bv_a, br_a, busy_a, done_a, err_a;
    logic [2:0]   cs_a, bs_a;
    logic [3:0]   cc_a;
    logic [15:0]  bd_a;

    logic [95:0]  rd_b;
    logic         cv_b, cr_b, bv_b, br_b, busy_b, done_b, err_b;
    logic [3:0]   cs_b, bs_b;
    logic [3:0]   cc_b;
    logic [15:0]  bd_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bus_read_sequencer #(.WIDTH(16), .NUM_REGS(8), .SEL_W(3), .CNT_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .reg_data_i(rd_a),
        .cmd_valid_i(cv_a), .cmd_ready_o(cr_a), .cmd_sel_i(cs_a), .cmd_count_i(cc_a),
        .bus_data_o(bd_a), .bus_sel_o(bs_a), .bus_valid_o(bv_a), .bus_ready_i(br_a),
        .busy_o(busy_a), .done_o(done_a), .err_o(err_a)
    );

    bus_read_sequencer #(.WIDTH(16), .NUM_REGS(6), .SEL_W(4), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .reg_data_i(rd_b),
        .cmd_valid_i(cv_b), .cmd_ready_o(cr_b), .cmd_sel_i(cs_b), .cmd_count_i(cc_b),
        .bus_data_o(bd_b), .bus_sel_o(bs_b), .bus_valid_o(bv_b), .bus_ready_i(br_b),
        .busy_o(busy_b), .done_o(done_b), .err_o(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input bit b, input int sel, input int cnt);
        if (!b) begin
            cv_a = 1'b1; cs_a = 3'(sel); cc_a = 4'(cnt);
        end else begin
            cv_b = 1'b1; cs_b = 4'(sel); cc_b = 4'(cnt);
        end
        tick();
        cv_a = 1'b0;
        cv_b = 1'b0;
    endtask

    // Called in the cycle after acceptance, with bus_ready held high.
    task automatic burst(input bit b, input string tag, input int sel, input int cnt);
        int n    = b ? 6 : 8;
        int base = b ? 'h2000 : 'h1000;
        int idx  = sel;
        int last = sel;
        for (int k = 0; k < cnt; k++) begin
            chk($sformatf("%s b%0d valid", tag, k), b ? bv_b : bv_a, 1);
            chk($sformatf("%s b%0d sel",   tag, k), b ? bs_b : {1'b0, bs_a}, idx);
            chk($sformatf("%s b%0d data",  tag, k), b ? bd_b : bd_a, base + idx);
            chk($sformatf("%s b%0d busy",  tag, k), b ? busy_b : busy_a, 1);
            chk($sformatf("%s b%0d rdy",   tag, k), b ? cr_b : cr_a, 0);
            last = idx;
            idx  = (idx + 1) % n;
            tick();
        end
        chk({tag, " done"},      b ? done_b : done_a, 1);
        chk({tag, " done vld"},  b ? bv_b : bv_a, 0);
        chk({tag, " done busy"}, b ? busy_b : busy_a, 1);
        chk({tag, " hold data"}, b ? bd_b : bd_a, base + last);
        chk({tag, " hold sel"},  b ? bs_b : {1'b0, bs_a}, last);
        tick();
        chk({tag, " idle done"}, b ? done_b : done_a, 0);
        chk({tag, " idle busy"}, b ? busy_b : busy_a, 0);
        chk({tag, " idle rdy"},  b ? cr_b : cr_a, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rd_a[i*16 +: 16] = 16'(16'h1000 + i);
        for (int i = 0; i < 6; i++) rd_b[i*16 +: 16] = 16'(16'h2000 + i);
        cv_a = 0; cs_a = 0; cc_a = 0; br_a = 1;
        cv_b = 0; cs_b = 0; cc_b = 0; br_b = 1;

        // Reset state
        reset = 1'b1;
        tick(); tick();
        chk("rst rdy",   cr_a, 0);
        chk("rst valid", bv_a, 0);
        chk("rst data",  bd_a, 0);
        chk("rst sel",   bs_a, 0);
        chk("rst busy",  busy_a, 0);
        chk("rst done",  done_a, 0);
        chk("rst err",   err_a, 0);
        reset = 1'b0;
        tick();
        chk("post rst rdy", cr_a, 1);

        // 1: sel 2, count 3 -> 1002, 1003, 1004
        send(0, 2, 3);
        burst(0, "t1", 2, 3);

        // 2: sel 6, count 4 -> 6, 7, 0, 1
        send(0, 6, 4);
        burst(0, "t2", 6, 4);

        // count larger than NUM_REGS
        send(0, 0, 9);
        burst(0, "t2w", 0, 9);

        // 3: stall on beat 2, reg[3] overwritten mid-stall
        send(0, 2, 3);
        chk("t3 b0 data", bd_a, 16'h1002);
        tick();
        br_a = 1'b0;
        chk("t3 b1 data", bd_a, 16'h1003);
        tick();
        rd_a[3*16 +: 16] = 16'hBEEF;
        chk("t3 st1 data",  bd_a, 16'h1003);
        chk("t3 st1 valid", bv_a, 1);
        tick();
        chk("t3 st2 data", bd_a, 16'h1003);
        tick();
        chk("t3 st3 data", bd_a, 16'h1003);
        chk("t3 st3 sel",  bs_a, 3);
        br_a = 1'b1;
        tick();
        chk("t3 b2 data", bd_a, 16'h1004);
        chk("t3 b2 sel",  bs_a, 4);
        tick();
        chk("t3 done",      done_a, 1);
        chk("t3 done data", bd_a, 16'h1004);
        tick();
        rd_a[3*16 +: 16] = 16'h1003;

        // 4: rejected commands
        send(0, 1, 0);
        chk("t4 cnt0 err",   err_a, 1);
        chk("t4 cnt0 valid", bv_a, 0);
        chk("t4 cnt0 busy",  busy_a, 0);
        tick();
        chk("t4 cnt0 err off", err_a, 0);
        chk("t4 cnt0 valid2",  bv_a, 0);
        chk("t4 cnt0 rdy",     cr_a, 1);
        send(1, 9, 2);
        chk("t4 sel9 err",   err_b, 1);
        chk("t4 sel9 valid", bv_b, 0);
        tick();
        chk("t4 sel9 err off", err_b, 0);
        chk("t4 sel9 valid2",  bv_b, 0);
        send(1, 6, 1);
        chk("t4 sel6 err", err_b, 1);
        tick();

        // wrap mod 6 on instance B: 4, 5, 0
        send(1, 4, 3);
        burst(1, "t4w", 4, 3);

        // 5: reset during beat 2 of count 5
        send(0, 0, 5);
        chk("t5 b0 sel", bs_a, 0);
        tick();
        chk("t5 b1 sel", bs_a, 1);
        reset = 1'b1;
        tick();
        chk("t5 rst valid", bv_a, 0);
        chk("t5 rst data",  bd_a, 0);
        chk("t5 rst sel",   bs_a, 0);
        chk("t5 rst busy",  busy_a, 0);
        chk("t5 rst done",  done_a, 0);
        chk("t5 rst err",   err_a, 0);
        chk("t5 rst rdy",   cr_a, 0);
        reset = 1'b0;
        tick();
        chk("t5 post rdy",   cr_a, 1);
        chk("t5 post done",  done_a, 0);
        chk("t5 post valid", bv_a, 0);
        send(0, 5, 2);
        burst(0, "t5n", 5, 2);

        // 6: cmd_valid held high through a burst
        cv_a = 1'b1; cs_a = 3'd1; cc_a = 4'd2;
        tick();
        cs_a = 3'd3; cc_a = 4'd1;
        chk("t6 b0 sel", bs_a, 1);
        chk("t6 b0 rdy", cr_a, 0);
        tick();
        chk("t6 b1 sel", bs_a, 2);
        tick();
        chk("t6 done",     done_a, 1);
        chk("t6 done rdy", cr_a, 0);
        chk("t6 done sel", bs_a, 2);
        tick();
        chk("t6 idle rdy",   cr_a, 1);
        chk("t6 idle busy",  busy_a, 0);
        chk("t6 idle valid", bv_a, 0);
        tick();
        cv_a = 1'b0;
        chk("t6 c2 valid", bv_a, 1);
        chk("t6 c2 sel",   bs_a, 3);
        chk("t6 c2 data",  bd_a, 16'h1003);
        tick();
        chk("t6 c2 done", done_a, 1);
        tick();
        chk("t6 c2 idle", cr_a, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
